// File: rtl/octal_counter_scheduler.sv
// Round-robin arbiter that lends one shared octal_counter to NREQ clients,
// issuing a fixed-length burst of count enables per grant and reporting status.
module octal_counter_scheduler #(
   parameter int NREQ = 4,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req,
   input  logic [3*NREQ-1:0] len,
   input  logic [2:0]        cnt_val,
   input  logic              cnt_cy,
   output logic              cnt_en,
   output logic [NREQ-1:0]   gnt,
   output logic              busy,
   output logic              done,
   output logic [IDW-1:0]    done_id,
   output logic [2:0]        start_val,
   output logic [2:0]        end_val,
   output logic              wrapped,
   output logic              aborted
);

   typedef enum logic [1:0] {IDLE, GRANT, RUN, DONE} state_t;

   state_t          state, state_nxt;
   logic [IDW-1:0]  ptr;
   logic [IDW-1:0]  owner;
   logic [IDW-1:0]  pick;
   logic            pick_valid;
   logic            owner_req;
   logic [2:0]      owner_len;
   logic [2:0]      remaining;
   logic [2:0]      end_hold;
   int              scan_idx;

   // Search starts at ptr so the most recently served client goes last.
   always_comb begin
      pick       = '0;
      pick_valid = 1'b0;
      scan_idx   = 0;
      for (int i = 0; i < NREQ; i++) begin
         scan_idx = (int'(ptr) + i) % NREQ;
         if (!pick_valid && req[scan_idx]) begin
            pick_valid = 1'b1;
            pick       = IDW'(scan_idx);
         end
      end
   end

   assign owner_req = req[owner];
   assign owner_len = len[int'(owner)*3 +: 3];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (pick_valid) state_nxt = GRANT;
         GRANT:   state_nxt = owner_req ? RUN : DONE;
         RUN:     if (!owner_req || remaining == 3'd0) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Burst bookkeeping; length is latched at GRANT so later len edits are ignored.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr       <= '0;
         owner     <= '0;
         gnt       <= '0;
         remaining <= '0;
         start_val <= '0;
         end_hold  <= '0;
         wrapped   <= 1'b0;
         aborted   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (pick_valid) begin
                  owner <= pick;
                  gnt   <= NREQ'(1) << pick;
               end
            end
            GRANT: begin
               remaining <= owner_len;
               start_val <= cnt_val;
               wrapped   <= 1'b0;
               aborted   <= !owner_req;
            end
            RUN: begin
               if (cnt_cy) wrapped <= 1'b1;
               if (!owner_req)
                  aborted <= 1'b1;
               else if (remaining != 3'd0)
                  remaining <= remaining - 3'd1;
            end
            DONE: begin
               end_hold <= cnt_val;
               gnt      <= '0;
               ptr      <= (owner == IDW'(NREQ-1)) ? '0 : owner + IDW'(1);
            end
            default: ;
         endcase
      end
   end

   assign cnt_en  = (state == RUN) && owner_req;
   assign busy    = (state != IDLE);
   assign done    = (state == DONE);
   assign done_id = owner;
   assign end_val = done ? cnt_val : end_hold;

endmodule

// File: tb/tb_octal_counter_scheduler.sv
// Directed bench for octal_counter_scheduler with a behavioural octal counter
// closing the loop on cnt_en/cnt_val/cnt_cy.
module tb_octal_counter_scheduler;

   logic        clk;
   logic        rst;
   logic [3:0]  req;
   logic [11:0] len;
   logic [2:0]  cnt_val;
   logic        cnt_cy;
   logic        cnt_en;
   logic [3:0]  gnt;
   logic        busy;
   logic        done;
   logic [1:0]  done_id;
   logic [2:0]  start_val;
   logic [2:0]  end_val;
   logic        wrapped;
   logic        aborted;

   logic [2:0]  cntr;
   logic        load;
   logic [2:0]  load_val;

   int checks;
   int errors;

   octal_counter_scheduler #(.NREQ(4), .IDW(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .len       (len),
      .cnt_val   (cnt_val),
      .cnt_cy    (cnt_cy),
      .cnt_en    (cnt_en),
      .gnt       (gnt),
      .busy      (busy),
      .done      (done),
      .done_id   (done_id),
      .start_val (start_val),
      .end_val   (end_val),
      .wrapped   (wrapped),
      .aborted   (aborted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference octal counter: carry is high while counting out of 7.
   always @(posedge clk) begin
      if (load)        cntr <= load_val;
      else if (cnt_en) cntr <= cntr + 3'd1;
   end
   assign cnt_val = cntr;
   assign cnt_cy  = cnt_en && (cntr == 3'd7);

   typedef struct {
      logic [3:0]  req;
      logic [11:0] len;
      logic [3:0]  gnt;
      logic        en;
      logic        busy;
      logic        done;
      logic [1:0]  did;
      logic [2:0]  sv;
      logic [2:0]  ev;
      logic        wr;
      logic        ab;
   } vec_t;

   vec_t tbl[7];

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic [3:0] r, input logic [11:0] l);
      req = r;
      len = l;
   endtask

   // Watches one burst: first grant seen, enables counted, stops on done.
   task automatic observeBurst(output logic [3:0] g, output int ens, output logic seen);
      g = '0; ens = 0; seen = 1'b0;
      for (int c = 0; c < 40 && !seen; c++) begin
         @(negedge clk); #1;
         if (gnt != 4'b0 && g == 4'b0) g = gnt;
         if (cnt_en) ens++;
         if (done) seen = 1'b1;
      end
   endtask

   task automatic waitEnable(output logic ok);
      ok = 1'b0;
      for (int c = 0; c < 10 && !ok; c++) begin
         @(negedge clk); #1;
         if (cnt_en) ok = 1'b1;
      end
   endtask

   task automatic resetDut();
      @(negedge clk); rst = 1'b0;
      @(negedge clk); rst = 1'b1;
   endtask

   logic [3:0] g;
   int         ens;
   logic       seen;
   logic       ok;
   logic [2:0] sv_abort;

   initial begin
      checks = 0; errors = 0;
      rst = 1'b0; req = '0; len = '0; load = 1'b1; load_val = 3'd0;

      tbl[0] = '{4'b0001, 12'h002, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 3'd0, 1'b0, 1'b0};
      tbl[1] = '{4'b0001, 12'h002, 4'b0001, 1'b0, 1'b1, 1'b0, 2'd0, 3'd0, 3'd0, 1'b0, 1'b0};
      tbl[2] = '{4'b0001, 12'h002, 4'b0001, 1'b1, 1'b1, 1'b0, 2'd0, 3'd0, 3'd0, 1'b0, 1'b0};
      tbl[3] = '{4'b0001, 12'h002, 4'b0001, 1'b1, 1'b1, 1'b0, 2'd0, 3'd0, 3'd0, 1'b0, 1'b0};
      tbl[4] = '{4'b0001, 12'h002, 4'b0001, 1'b1, 1'b1, 1'b0, 2'd0, 3'd0, 3'd0, 1'b0, 1'b0};
      tbl[5] = '{4'b0000, 12'h002, 4'b0001, 1'b0, 1'b1, 1'b1, 2'd0, 3'd0, 3'd3, 1'b0, 1'b0};
      tbl[6] = '{4'b0000, 12'h002, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 3'd3, 1'b0, 1'b0};

      repeat (2) @(negedge clk);
      #1;
      checkOutput("reset state",
                  {15'd0, gnt, cnt_en, busy, done, done_id, start_val, end_val, wrapped, aborted}, 32'd0);

      // Single burst of len0+1 = 3 enables, counter starting from 0.
      @(negedge clk);
      rst = 1'b1; load = 1'b0;
      for (int i = 0; i < 7; i++) begin
         if (i > 0) @(negedge clk);
         applyStimulus(tbl[i].req, tbl[i].len);
         #1;
         checkOutput($sformatf("single burst vec %0d", i),
                     {15'd0, gnt, cnt_en, busy, done, done_id, start_val, end_val, wrapped, aborted},
                     {15'd0, tbl[i].gnt, tbl[i].en, tbl[i].busy, tbl[i].done, tbl[i].did,
                      tbl[i].sv, tbl[i].ev, tbl[i].wr, tbl[i].ab});
      end

      // Fairness with all requests held and single-enable bursts.
      resetDut();
      applyStimulus(4'b1111, 12'h000);
      for (int b = 0; b < 6; b++) begin
         observeBurst(g, ens, seen);
         if (b == 5) req = 4'b0000;
         checkOutput($sformatf("fair grant %0d", b), {28'd0, g}, 32'd1 << (b % 4));
         checkOutput($sformatf("fair enables %0d", b), ens, 32'd1);
         checkOutput($sformatf("fair done %0d", b), {31'd0, seen}, 32'd1);
         checkOutput($sformatf("fair done_id %0d", b), {30'd0, done_id}, b % 4);
      end

      // Wrap: 8 enables from 3 pass through 7 and return to 3.
      @(negedge clk); load = 1'b1; load_val = 3'd3;
      @(negedge clk); load = 1'b0;
      applyStimulus(4'b0100, 12'h1C0);
      observeBurst(g, ens, seen);
      req = 4'b0000;
      checkOutput("wrap grant", {28'd0, g}, 32'h4);
      checkOutput("wrap enables", ens, 32'd8);
      checkOutput("wrap status",
                  {22'd0, seen, done_id, start_val, end_val, wrapped, aborted},
                  {22'd0, 1'b1, 2'd2, 3'd3, 3'd3, 1'b1, 1'b0});

      // Abort: owner 1 drops its request after two enables.
      @(negedge clk);
      applyStimulus(4'b0010, 12'h038);
      waitEnable(ok);
      checkOutput("abort first enable", {31'd0, ok}, 32'd1);
      sv_abort = start_val;
      checkOutput("abort start_val", {29'd0, start_val}, 32'd3);
      @(negedge clk); #1;
      checkOutput("abort second enable", {31'd0, cnt_en}, 32'd1);
      @(negedge clk); req = 4'b0000; #1;
      checkOutput("abort drop cycle", {29'd0, cnt_en, busy, done}, 32'b010);
      @(negedge clk); #1;
      checkOutput("abort done",
                  {24'd0, done, aborted, wrapped, done_id, end_val},
                  {24'd0, 1'b1, 1'b1, 1'b0, 2'd1, sv_abort + 3'd2});
      applyStimulus(4'b0110, 12'h000);
      observeBurst(g, ens, seen);
      req = 4'b0000;
      checkOutput("ptr after abort", {28'd0, g}, 32'h4);

      // Asynchronous reset during the 4th enable of a long burst.
      @(negedge clk);
      applyStimulus(4'b0001, 12'h007);
      waitEnable(ok);
      checkOutput("reset-run first enable", {31'd0, ok}, 32'd1);
      repeat (3) begin @(negedge clk); #1; end
      checkOutput("reset-run 4th enable", {31'd0, cnt_en}, 32'd1);
      #1 rst = 1'b0;
      #1;
      checkOutput("async reset outputs", {25'd0, gnt, cnt_en, busy, done}, 32'd0);
      @(negedge clk); #1;
      checkOutput("no done in reset", {31'd0, done}, 32'd0);
      applyStimulus(4'b0011, 12'h000);
      rst = 1'b1;
      observeBurst(g, ens, seen);
      req = 4'b0010;
      checkOutput("post-reset first grant", {28'd0, g}, 32'h1);
      checkOutput("post-reset done_id", {30'd0, done_id}, 32'd0);
      observeBurst(g, ens, seen);
      req = 4'b0000;
      checkOutput("post-reset second grant", {28'd0, g}, 32'h2);

      // Non-owner request and owner len edits mid-burst are ignored.
      @(negedge clk);
      applyStimulus(4'b0001, 12'h003);
      waitEnable(ok);
      ens = ok ? 1 : 0;
      seen = 1'b0;
      @(negedge clk);
      applyStimulus(4'b1001, 12'h000);
      #1;
      if (cnt_en) ens++;
      for (int c = 0; c < 20 && !seen; c++) begin
         @(negedge clk); #1;
         if (cnt_en) ens++;
         if (done) seen = 1'b1;
      end
      checkOutput("late owner enables", ens, 32'd4);
      checkOutput("late owner done", {29'd0, seen, done_id}, {29'd0, 1'b1, 2'd0});
      req = 4'b1000;
      @(negedge clk); #1;
      checkOutput("late idle", {27'd0, gnt, busy}, 32'd0);
      @(negedge clk); #1;
      checkOutput("late grant 3", {27'd0, gnt, busy}, {27'd0, 4'b1000, 1'b1});
      req = 4'b0000;
      seen = 1'b0;
      for (int c = 0; c < 10 && !seen; c++) begin
         @(negedge clk); #1;
         if (!busy) seen = 1'b1;
      end
      checkOutput("final idle", {31'd0, seen}, 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
